// File: rtl/hazard_ctrl_param.sv
// hazard_ctrl_param: operand forwarding plus branch-freeze FSM driving the fetch PC
module hazard_ctrl_param #(
    parameter int XLEN                  = 32,
    parameter int RA_W                  = 5,
    parameter int FWD_STAGES            = 2,
    parameter int BRANCH_WAIT           = 1,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int CNT_W                 = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [RA_W-1:0]            rs1,
    input  logic [RA_W-1:0]            rs2,
    input  logic [XLEN-1:0]            rd1,
    input  logic [XLEN-1:0]            rd2,
    input  logic [FWD_STAGES-1:0]      fwd_we,
    input  logic [FWD_STAGES*RA_W-1:0] fwd_rd,
    input  logic [FWD_STAGES*XLEN-1:0] fwd_data,
    input  logic                       branch,
    input  logic [XLEN-1:0]            pc_branch,
    input  logic [XLEN-1:0]            pc_plus4,
    output logic                       freeze,
    output logic [XLEN-1:0]            pc_target,
    output logic [XLEN-1:0]            src_a,
    output logic [XLEN-1:0]            src_b,
    output logic [CNT_W-1:0]           branch_cnt
);
    if (BRANCH_WAIT > 15 || FWD_STAGES < 1) begin : g_bad_param
        $error("hazard_ctrl_param: BRANCH_WAIT must be 0..15 and FWD_STAGES >= 1");
    end

    typedef enum logic [2:0] {BOOT, RUN, WAIT, REDIRECT, RELEASE} state_t;

    state_t            state_q, state_d;
    logic              freeze_q, freeze_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]  bc_q, bc_d;

    // Walk from oldest to youngest so the lowest-index match wins.
    always_comb begin
        src_a = rd1;
        src_b = rd2;
        for (int i = FWD_STAGES - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_rd[i*RA_W +: RA_W] == rs1 && rs1 != '0)
                src_a = fwd_data[i*XLEN +: XLEN];
            if (fwd_we[i] && fwd_rd[i*RA_W +: RA_W] == rs2 && rs2 != '0)
                src_b = fwd_data[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        freeze_d = freeze_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        bc_d     = bc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (branch) begin
                    freeze_d = 1'b1;
                    cnt_d    = 4'(BRANCH_WAIT);
                    state_d  = (BRANCH_WAIT > 0) ? WAIT : REDIRECT;
                end else begin
                    pc_d = pc_plus4;
                end
            end
            WAIT: begin
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? REDIRECT : WAIT;
            end
            REDIRECT: begin
                pc_d    = pc_branch;
                bc_d    = &bc_q ? bc_q : bc_q + CNT_W'(1);
                state_d = RELEASE;
            end
            RELEASE: begin
                freeze_d = 1'b0;
                pc_d     = pc_plus4;
                state_d  = RUN;
            end
            default: begin
                freeze_d = 1'b0;
                state_d  = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            freeze_q <= 1'b0;
            pc_q     <= RESET_PC;
            cnt_q    <= '0;
            bc_q     <= '0;
        end else begin
            state_q  <= state_d;
            freeze_q <= freeze_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            bc_q     <= bc_d;
        end
    end

    assign freeze     = freeze_q;
    assign pc_target  = pc_q;
    assign branch_cnt = bc_q;
endmodule

// File: tb/tb_hazard_ctrl_param.sv
// tb_hazard_ctrl_param: directed checks on default, BRANCH_WAIT=0 and CNT_W=2 builds
module tb_hazard_ctrl_param;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1, rs2;
    logic [31:0] rd1, rd2;
    logic [1:0]  fwd_we;
    logic [9:0]  fwd_rd;
    logic [63:0] fwd_data;
    logic        br_a, br_b, br_c;
    logic [31:0] pc_branch, pc_plus4;

    logic        frz_a, frz_b, frz_c;
    logic [31:0] pc_a, pc_b, pc_c;
    logic [31:0] sa_a, sb_a, sa_b, sb_b, sa_c, sb_c;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0]  cnt_c;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl_param u_a (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .branch(br_a),
        .pc_branch(pc_branch), .pc_plus4(pc_plus4), .freeze(frz_a),
        .pc_target(pc_a), .src_a(sa_a), .src_b(sb_a), .branch_cnt(cnt_a));

    hazard_ctrl_param #(.BRANCH_WAIT(0)) u_b (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .branch(br_b),
        .pc_branch(pc_branch), .pc_plus4(pc_plus4), .freeze(frz_b),
        .pc_target(pc_b), .src_a(sa_b), .src_b(sb_b), .branch_cnt(cnt_b));

    hazard_ctrl_param #(.CNT_W(2)) u_c (
        .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd1(rd1), .rd2(rd2),
        .fwd_we(fwd_we), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .branch(br_c),
        .pc_branch(pc_branch), .pc_plus4(pc_plus4), .freeze(frz_c),
        .pc_target(pc_c), .src_a(sa_c), .src_b(sb_c), .branch_cnt(cnt_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rs1 = '0; rs2 = '0; rd1 = '0; rd2 = '0;
        fwd_we = '0; fwd_rd = '0; fwd_data = '0;
        br_a = 1'b0; br_b = 1'b0; br_c = 1'b0;
        pc_branch = '0; pc_plus4 = 32'd4;
        cyc();
        chk("rst_pc_a", pc_a, 32'd0);
        chk("rst_frz_a", 32'(frz_a), 32'd0);
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_pc_b", pc_b, 32'd0);
        rst = 1'b0;
        cyc();
        chk("boot_hold", pc_a, 32'd0);
        cyc();
        chk("run_pc4", pc_a, 32'd4);
        pc_plus4 = 32'd8;
        cyc();
        chk("run_pc8", pc_a, 32'd8);
        pc_plus4 = 32'd12;
        cyc();
        chk("run_pc12", pc_a, 32'd12);
        chk("run_frz", 32'(frz_a), 32'd0);

        rs1 = 5'd5; rd1 = 32'h111; fwd_we = 2'b11; fwd_rd = {5'd5, 5'd5};
        fwd_data = {32'hBB, 32'hAA};
        #1 chk("fwd_young", sa_a, 32'hAA);
        fwd_we = 2'b10;
        #1 chk("fwd_old", sa_a, 32'hBB);
        fwd_we = 2'b00;
        #1 chk("fwd_none", sa_a, 32'h111);
        rs1 = 5'd0; fwd_we = 2'b11; fwd_rd = {5'd0, 5'd0};
        #1 chk("fwd_r0", sa_a, 32'h111);
        rs2 = 5'd7; rd2 = 32'h222; fwd_rd = {5'd5, 5'd7};
        #1 chk("fwdb_src0", sb_a, 32'hAA);
        rs2 = 5'd5;
        #1 chk("fwdb_src1", sb_a, 32'hBB);
        rs2 = 5'd9;
        #1 chk("fwdb_none", sb_a, 32'h222);
        fwd_we = 2'b00;

        pc_plus4 = 32'd16; pc_branch = 32'h40; br_a = 1'b1; br_b = 1'b1;
        cyc();
        br_a = 1'b0; br_b = 1'b0;
        chk("br_frz1_a", 32'(frz_a), 32'd1);
        chk("br_hold_a", pc_a, 32'd12);
        chk("br_frz1_b", 32'(frz_b), 32'd1);
        chk("nobr_c", pc_c, 32'd16);
        pc_plus4 = 32'd20;
        cyc();
        chk("br_frz2_a", 32'(frz_a), 32'd1);
        chk("br_hold2_a", pc_a, 32'd12);
        chk("bw0_redir", pc_b, 32'h40);
        chk("bw0_frz2", 32'(frz_b), 32'd1);
        chk("bw0_cnt", 32'(cnt_b), 32'd1);
        cyc();
        chk("br_redir_a", pc_a, 32'h40);
        chk("br_frz3_a", 32'(frz_a), 32'd1);
        chk("br_cnt_a", 32'(cnt_a), 32'd1);
        chk("bw0_rel_frz", 32'(frz_b), 32'd0);
        chk("bw0_rel_pc", pc_b, 32'd20);
        cyc();
        chk("rel_frz_a", 32'(frz_a), 32'd0);
        chk("rel_pc_a", pc_a, 32'd20);

        pc_plus4 = 32'd24; pc_branch = 32'h80; br_a = 1'b1;
        cyc();
        chk("hold_frz1", 32'(frz_a), 32'd1);
        cyc();
        chk("hold_frz2", 32'(frz_a), 32'd1);
        chk("hold_pc2", pc_a, 32'd20);
        cyc();
        chk("hold_redir", pc_a, 32'h80);
        chk("hold_cnt", 32'(cnt_a), 32'd2);
        cyc();
        chk("hold_rel_frz", 32'(frz_a), 32'd0);
        chk("hold_rel_pc", pc_a, 32'd24);
        cyc();
        chk("hold_reaccept", 32'(frz_a), 32'd1);
        chk("hold_reaccept_pc", pc_a, 32'd24);

        br_a = 1'b0; rst = 1'b1;
        cyc();
        chk("midrst_frz", 32'(frz_a), 32'd0);
        chk("midrst_pc", pc_a, 32'd0);
        chk("midrst_cnt", 32'(cnt_a), 32'd0);
        rst = 1'b0;
        cyc();
        for (int k = 1; k <= 5; k++) begin
            br_c = 1'b1;
            cyc();
            br_c = 1'b0;
            cyc(); cyc(); cyc();
            chk($sformatf("sat_cnt_%0d", k), 32'(cnt_c), (k > 3) ? 32'd3 : 32'(k));
        end
        chk("sat_frz", 32'(frz_c), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
